ysyx_24080014_axi_arbiter: RTL and testbench

Two-master AXI4-lite arbiter that shares the single memory-side AXI4-lite port (memory, UART and CLINT decode) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write). The arbiter grants one whole transaction at a time, routes the downstream response back to the owner, and holds every non-owner channel stalled. It sits between the core's IFU/LSU and the existing memory access wrapper.

---
 rtl/ysyx_24080014_axi_pkg.sv | 27 ++
 rtl/ysyx_24080014_arb_pick.sv | 39 +++
 rtl/ysyx_24080014_axi_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ysyx_24080014_axi_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080014_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24080014_axi_pkg
//  Description : Shared definitions for the IFU/LSU AXI4-lite arbiter:
//                FSM state encoding, owner IDs and AXI response codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24080014_axi_pkg;

    // One whole transaction is owned per non-IDLE state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } arb_state_e;

    // Owner IDs; also used as the round-robin pointer value
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ysyx_24080014_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24080014_arb_pick
//  Description : Combinational two-way read picker. grant[0] = IFU,
//                grant[1] = LSU, one-hot or zero.
//                ARB_RR_EN defined  : on a tie the master that is not the
//                                     last owner (ptr) wins.
//                ARB_RR_EN undefined: on a tie LSU wins; no ptr port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24080014_arb_pick
    import ysyx_24080014_axi_pkg::*;
(
    input  logic       req_ifu,
    input  logic       req_lsu,
`ifdef ARB_RR_EN
    input  logic       ptr,
`endif
    output logic [1:0] grant
);

    // Tie-break rule, then single-request pass-through
    always_comb begin
        grant = 2'b00;
        if (req_ifu && req_lsu) begin
`ifdef ARB_RR_EN
            grant = (ptr == OWN_IFU) ? 2'b10 : 2'b01;
`else
            grant = 2'b10;
`endif
        end else if (req_lsu) begin
            grant = 2'b10;
        end else if (req_ifu) begin
            grant = 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_24080014_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24080014_axi_arbiter
//  Description : Two-master AXI4-lite arbiter (IFU read-only, LSU read/write)
//                onto one downstream AXI4-lite port. One whole transaction is
//                granted at a time; writes beat reads. Optional macro
//                ARB_RR_EN selects round-robin between reads, otherwise LSU
//                reads have fixed priority over IFU reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24080014_axi_arbiter
    import ysyx_24080014_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // IFU read
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    // LSU read
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    // LSU write
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    output logic [1:0]            lsu_bresp,
    // Downstream master port
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_W-1:0]     m_araddr,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp
);

    arb_state_e state, state_next;
    logic       owner;
    logic       ar_done, aw_done, w_done;
    logic [1:0] grant;
    logic       rd_active;

`ifdef ARB_RR_EN
    logic ptr;

    ysyx_24080014_arb_pick u_pick (
        .req_ifu (ifu_arvalid),
        .req_lsu (lsu_arvalid),
        .ptr     (ptr),
        .grant   (grant)
    );

    // Pointer remembers the last read owner; writes leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= OWN_IFU;
        end else if (state == IDLE && !lsu_awvalid && grant != 2'b00) begin
            ptr <= grant[1] ? OWN_LSU : OWN_IFU;
        end
    end
`else
    ysyx_24080014_arb_pick u_pick (
        .req_ifu (ifu_arvalid),
        .req_lsu (lsu_arvalid),
        .grant   (grant)
    );
`endif

    // State and owner registers; owner is latched with each grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_IFU;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (lsu_awvalid || grant[1]) owner <= OWN_LSU;
                else if (grant[0])           owner <= OWN_IFU;
            end
        end
    end

    // Next-state: writes first, then the picker's read choice
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (lsu_awvalid)   state_next = LSU_WR;
                else if (grant[1]) state_next = LSU_RD;
                else if (grant[0]) state_next = IFU_RD;
            end
            IFU_RD, LSU_RD: if (m_rvalid && m_rready) state_next = IDLE;
            LSU_WR:         if (m_bvalid && m_bready) state_next = IDLE;
            default:        state_next = IDLE;
        endcase
    end

    // Address/data handshake flags; cleared in every IDLE cycle
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (m_arvalid && m_arready) ar_done <= 1'b1;
            if (m_awvalid && m_awready) aw_done <= 1'b1;
            if (m_wvalid  && m_wready)  w_done  <= 1'b1;
        end
    end

    assign rd_active = (state == IFU_RD) || (state == LSU_RD);

    // Forwarding from the registered owner; everything else held at 0
    always_comb begin
        m_arvalid   = 1'b0;
        m_araddr    = '0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_awaddr    = '0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = '0;
        if (rd_active && owner == OWN_IFU) begin
            m_arvalid   = ifu_arvalid & ~ar_done;
            m_araddr    = ifu_araddr;
            ifu_arready = m_arready & ~ar_done;
            m_rready    = ifu_rready;
            ifu_rvalid  = m_rvalid;
            ifu_rdata   = m_rdata;
            ifu_rresp   = m_rresp;
        end else if (rd_active) begin
            m_arvalid   = lsu_arvalid & ~ar_done;
            m_araddr    = lsu_araddr;
            lsu_arready = m_arready & ~ar_done;
            m_rready    = lsu_rready;
            lsu_rvalid  = m_rvalid;
            lsu_rdata   = m_rdata;
            lsu_rresp   = m_rresp;
        end else if (state == LSU_WR) begin
            m_awvalid   = lsu_awvalid & ~aw_done;
            m_awaddr    = lsu_awaddr;
            lsu_awready = m_awready & ~aw_done;
            m_wvalid    = lsu_wvalid & ~w_done;
            m_wdata     = lsu_wdata;
            m_wstrb     = lsu_wstrb;
            lsu_wready  = m_wready & ~w_done;
            m_bready    = lsu_bready;
            lsu_bvalid  = m_bvalid;
            lsu_bresp   = m_bresp;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080014_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24080014_axi_arbiter
//  Description : Directed self-checking bench for the IFU/LSU AXI4-lite
//                arbiter. Inputs change on the falling edge; outputs are
//                sampled 1 time unit later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24080014_axi_arbiter;
    import ysyx_24080014_axi_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [31:0] IFU_ADDR = 32'h8000_0000;
    localparam logic [31:0] LSU_ADDR = 32'h8000_1000;

    logic clk = 1'b0;
    logic rst;
    logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [ADDR_W-1:0] ifu_araddr;
    logic [DATA_W-1:0] ifu_rdata;
    logic [1:0] ifu_rresp;
    logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [ADDR_W-1:0] lsu_araddr, lsu_awaddr;
    logic [DATA_W-1:0] lsu_rdata, lsu_wdata;
    logic [1:0] lsu_rresp, lsu_bresp;
    logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [DATA_W/8-1:0] lsu_wstrb, m_wstrb;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic [ADDR_W-1:0] m_araddr, m_awaddr;
    logic [DATA_W-1:0] m_rdata, m_wdata;
    logic [1:0] m_rresp, m_bresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

    int chk_tot  = 0;
    int chk_pass = 0;

    always #5 clk = ~clk;

    ysyx_24080014_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    // Slave side of one read: waits for m_arvalid (bounded), accepts AR,
    // returns data addr+0x11 with OKAY, and drops the winner's arvalid.
    task automatic slave_read(output logic who_lsu, output logic [31:0] addr,
                              output logic [31:0] rdata, output logic loser_rdy,
                              output int waits);
        who_lsu = 1'b0; addr = '0; rdata = '0; loser_rdy = 1'b0; waits = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1;
            if (m_arvalid) begin
                waits = i;
                break;
            end
        end
        if (waits == 0) begin
            chk_tot++;
            $display("FAIL slave_read_timeout: m_arvalid=%b after 8 cycles, required 1", m_arvalid);
            return;
        end
        addr = m_araddr;
        m_arready = 1'b1; #1;
        who_lsu   = lsu_arready;
        loser_rdy = lsu_arready ? ifu_arready : lsu_arready;
        @(negedge clk);
        m_arready = 1'b0;
        if (who_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rdata = addr + 32'h11; m_rresp = RESP_OKAY; #1;
        rdata = who_lsu ? lsu_rdata : ifu_rdata;
        @(negedge clk);
        m_rvalid = 1'b0; m_rdata = '0; #1;
    endtask

    task automatic test_reset();
        logic who, lr; logic [31:0] a, d; int w;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk_tot++;
            if ({m_arvalid, ifu_arready, m_awvalid, lsu_bvalid, m_rready} !== 5'b0)
                $display("FAIL reset_outputs: got %b required 00000",
                         {m_arvalid, ifu_arready, m_awvalid, lsu_bvalid, m_rready});
            else chk_pass++;
        end
        chk_tot++;
        if (m_araddr !== 32'h0) $display("FAIL reset_araddr: got %h required 00000000", m_araddr);
        else chk_pass++;
        rst = 1'b0; #1;
        chk_tot++;
        if (m_arvalid !== 1'b0) $display("FAIL reset_release_same_cycle: m_arvalid=%b required 0", m_arvalid);
        else chk_pass++;
        slave_read(who, a, d, lr, w);
        chk_tot++;
        if (w !== 1) $display("FAIL reset_grant_latency: got %0d required 1", w); else chk_pass++;
        chk_tot++;
        if (a !== IFU_ADDR || who !== 1'b0) $display("FAIL reset_first_read: addr=%h lsu=%b required %h lsu=0", a, who, IFU_ADDR);
        else chk_pass++;
        chk_tot++;
        if (d !== IFU_ADDR + 32'h11) $display("FAIL reset_ifu_rdata: got %h required %h", d, IFU_ADDR + 32'h11);
        else chk_pass++;
    endtask

    task automatic test_simultaneous();
        logic who, lr; logic [31:0] a, d; int w;
        int ifu_left = 2, lsu_left = 2;
        logic [3:0] exp_lsu;
`ifdef ARB_RR_EN
        exp_lsu = 4'b0101;
`else
        exp_lsu = 4'b0011;
`endif
        for (int i = 0; i < 4; i++) begin
            ifu_arvalid = (ifu_left > 0); ifu_araddr = IFU_ADDR;
            lsu_arvalid = (lsu_left > 0); lsu_araddr = LSU_ADDR;
            slave_read(who, a, d, lr, w);
            if (who) lsu_left--; else ifu_left--;
            chk_tot++;
            if (who !== exp_lsu[i]) $display("FAIL sim_order[%0d]: lsu_won=%b required %b", i, who, exp_lsu[i]);
            else chk_pass++;
            chk_tot++;
            if (a !== (exp_lsu[i] ? LSU_ADDR : IFU_ADDR) || d !== a + 32'h11 || lr !== 1'b0)
                $display("FAIL sim_route[%0d]: addr=%h rdata=%h loser_ready=%b", i, a, d, lr);
            else chk_pass++;
        end
    endtask

    task automatic test_write_priority();
        logic who, lr; logic [31:0] a, d; int w;
        lsu_awvalid = 1'b1; lsu_awaddr = 32'ha000_03f8;
        lsu_wvalid = 1'b1; lsu_wdata = 32'h41; lsu_wstrb = 4'h1;
        ifu_arvalid = 1'b1; ifu_araddr = IFU_ADDR;
        @(negedge clk); m_arready = 1'b1; #1;
        chk_tot++;
        if ({m_awvalid, m_wvalid, m_arvalid, ifu_arready} !== 4'b1100 || m_awaddr !== 32'ha000_03f8 || m_wdata !== 32'h41)
            $display("FAIL wr_first: v=%b awaddr=%h wdata=%h required 1100 a00003f8 00000041",
                     {m_awvalid, m_wvalid, m_arvalid, ifu_arready}, m_awaddr, m_wdata);
        else chk_pass++;
        m_awready = 1'b1; m_wready = 1'b1;
        @(negedge clk);
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        m_bvalid = 1'b1; m_bresp = RESP_OKAY; #1;
        chk_tot++;
        if ({lsu_bvalid, ifu_arready, m_arvalid} !== 3'b100)
            $display("FAIL wr_bphase: bvalid,ifu_arready,m_arvalid=%b required 100", {lsu_bvalid, ifu_arready, m_arvalid});
        else chk_pass++;
        @(negedge clk); m_bvalid = 1'b0; #1;
        chk_tot++;
        if ({m_arvalid, ifu_arready, m_bready} !== 3'b000)
            $display("FAIL wr_idle_bubble: got %b required 000", {m_arvalid, ifu_arready, m_bready});
        else chk_pass++;
        slave_read(who, a, d, lr, w);
        chk_tot++;
        if (who !== 1'b0 || a !== IFU_ADDR || w !== 1)
            $display("FAIL wr_then_ifu: lsu=%b addr=%h waits=%0d required 0 %h 1", who, a, w, IFU_ADDR);
        else chk_pass++;
    endtask

    task automatic test_split_aw_w();
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_2000;
        lsu_wvalid = 1'b1; lsu_wdata = 32'h5a5a_0001; lsu_wstrb = 4'hf;
        @(negedge clk); m_awready = 1'b1; #1;
        chk_tot++;
        if ({m_awvalid, lsu_awready, m_wvalid} !== 3'b111)
            $display("FAIL split_c1: got %b required 111", {m_awvalid, lsu_awready, m_wvalid});
        else chk_pass++;
        @(negedge clk); m_awready = 1'b0; #1;
        chk_tot++;
        if ({m_awvalid, m_wvalid} !== 2'b01) $display("FAIL split_c2: aw,w=%b required 01", {m_awvalid, m_wvalid});
        else chk_pass++;
        @(negedge clk); m_wready = 1'b1; #1;
        chk_tot++;
        if ({m_awvalid, m_wvalid, lsu_wready} !== 3'b011)
            $display("FAIL split_c3: got %b required 011", {m_awvalid, m_wvalid, lsu_wready});
        else chk_pass++;
        @(negedge clk); m_wready = 1'b0; lsu_wvalid = 1'b0; #1;
        chk_tot++;
        if ({m_awvalid, m_wvalid, m_bready} !== 3'b001)
            $display("FAIL split_wait_b: got %b required 001", {m_awvalid, m_wvalid, m_bready});
        else chk_pass++;
        @(negedge clk); lsu_awvalid = 1'b0; m_bvalid = 1'b1; m_bresp = RESP_SLVERR; #1;
        chk_tot++;
        if (lsu_bvalid !== 1'b1 || lsu_bresp !== RESP_SLVERR)
            $display("FAIL split_b: bvalid=%b bresp=%b required 1 10", lsu_bvalid, lsu_bresp);
        else chk_pass++;
        @(negedge clk); m_bvalid = 1'b0; m_bresp = RESP_OKAY; #1;
        chk_tot++;
        if (m_bready !== 1'b0) $display("FAIL split_exit: m_bready=%b required 0", m_bready);
        else chk_pass++;
    endtask

    task automatic test_error_stall();
        logic who, lr; logic [31:0] a, d; int w;
        lsu_arvalid = 1'b1; lsu_araddr = LSU_ADDR; lsu_rready = 1'b0;
        @(negedge clk); m_arready = 1'b1; #1;
        chk_tot++;
        if (lsu_arready !== 1'b1) $display("FAIL err_ar: lsu_arready=%b required 1", lsu_arready);
        else chk_pass++;
        @(negedge clk);
        m_arready = 1'b0; lsu_arvalid = 1'b0; ifu_arvalid = 1'b1; ifu_araddr = IFU_ADDR;
        m_rvalid = 1'b1; m_rdata = 32'hdead_beef; m_rresp = RESP_SLVERR;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk_tot++;
            if ({lsu_rvalid, m_rready, ifu_arready, m_arvalid} !== 4'b1000 || lsu_rresp !== RESP_SLVERR)
                $display("FAIL err_stall[%0d]: v=%b rresp=%b required 1000 10", i,
                         {lsu_rvalid, m_rready, ifu_arready, m_arvalid}, lsu_rresp);
            else chk_pass++;
        end
        @(negedge clk); lsu_rready = 1'b1; #1;
        chk_tot++;
        if (m_rready !== 1'b1 || lsu_rdata !== 32'hdead_beef)
            $display("FAIL err_handshake: m_rready=%b rdata=%h required 1 deadbeef", m_rready, lsu_rdata);
        else chk_pass++;
        @(negedge clk); m_rvalid = 1'b0; m_rresp = RESP_OKAY; #1;
        chk_tot++;
        if (m_arvalid !== 1'b0) $display("FAIL err_idle: m_arvalid=%b required 0", m_arvalid);
        else chk_pass++;
        slave_read(who, a, d, lr, w);
        chk_tot++;
        if (who !== 1'b0 || a !== IFU_ADDR || w !== 1)
            $display("FAIL err_next_grant: lsu=%b addr=%h waits=%0d required 0 %h 1", who, a, w, IFU_ADDR);
        else chk_pass++;
    endtask

    task automatic test_mid_reset();
        logic who, lr; logic [31:0] a, d; int w;
        lsu_arvalid = 1'b1; lsu_araddr = LSU_ADDR;
        @(negedge clk); m_arready = 1'b1; #1;
        @(negedge clk); m_arready = 1'b0; lsu_arvalid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk_tot++;
        if ({m_arvalid, m_rready, lsu_rvalid, m_awvalid, m_wvalid, m_bready} !== 6'b0)
            $display("FAIL midrst_idle: got %b required 000000",
                     {m_arvalid, m_rready, lsu_rvalid, m_awvalid, m_wvalid, m_bready});
        else chk_pass++;
        // Last read owner was LSU; a cleared pointer lets LSU win the tie in both modes
        ifu_arvalid = 1'b1; ifu_araddr = IFU_ADDR;
        lsu_arvalid = 1'b1; lsu_araddr = LSU_ADDR;
        slave_read(who, a, d, lr, w);
        chk_tot++;
        if (who !== 1'b1 || a !== LSU_ADDR) $display("FAIL midrst_tie: lsu=%b addr=%h required 1 %h", who, a, LSU_ADDR);
        else chk_pass++;
        slave_read(who, a, d, lr, w);
        chk_tot++;
        if (who !== 1'b0 || a !== IFU_ADDR || d !== IFU_ADDR + 32'h11)
            $display("FAIL midrst_ifu: lsu=%b addr=%h rdata=%h required 0 %h %h", who, a, d, IFU_ADDR, IFU_ADDR + 32'h11);
        else chk_pass++;
    endtask

    initial begin
        rst = 1'b1;
        ifu_arvalid = 1'b1; ifu_araddr = IFU_ADDR; ifu_rready = 1'b1;
        lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_rready = 1'b1;
        lsu_awvalid = 1'b0; lsu_awaddr = '0; lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
        lsu_bready = 1'b1;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
        test_reset();
        test_simultaneous();
        test_write_priority();
        test_split_aw_w();
        test_error_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", chk_pass, chk_tot);
        $finish;
    end

endmodule
`default_nettype wire
